// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU.
// Grants one op at a time, executes it for one cycle, holds the result until consumed.
module alu_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_op_i,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,

    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_op_i,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,

    output logic        rsp0_valid_o,
    input  logic        rsp0_ready_i,
    output logic [31:0] rsp0_data_o,

    output logic        rsp1_valid_o,
    input  logic        rsp1_ready_i,
    output logic [31:0] rsp1_data_o,

    output logic [3:0]  alu_op_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    input  logic [31:0] alu_out_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;

    logic        any_valid;
    logic        win_id;
    logic        owner_ready;

    assign any_valid = req0_valid_i | req1_valid_i;
    assign owner_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;

    // Round-robin only matters on contention; a lone requester always wins.
    always_comb begin
        win_id = ~req0_valid_i;
        if (FIXED_PRIO == 0 && req0_valid_i && req1_valid_i) begin
            win_id = ~last_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp0_valid_o = 1'b0;
        rsp1_valid_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    req0_ready_o = ~win_id;
                    req1_ready_o = win_id;
                    state_d      = ST_EXEC;
                    owner_d      = win_id;
                    last_d       = win_id;
                    op_d         = win_id ? req1_op_i : req0_op_i;
                    a_d          = win_id ? req1_a_i : req0_a_i;
                    b_d          = win_id ? req1_b_i : req0_b_i;
                end
            end
            ST_EXEC: begin
                res_d   = alu_out_i;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid_o = ~owner_q;
                rsp1_valid_o = owner_q;
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rsp0_data_o = res_q;
    assign rsp1_data_o = res_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin (d0) and fixed-priority (d1) instances,
// a behavioural ALU, and a transaction-level reference model.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_SHIFTL  = 4'd1;
    localparam logic [3:0] ALU_SHIFTR  = 4'd2;
    localparam logic [3:0] ALU_SHIFTRA = 4'd3;
    localparam logic [3:0] ALU_ADD     = 4'd4;
    localparam logic [3:0] ALU_SUB     = 4'd6;
    localparam logic [3:0] ALU_AND     = 4'd7;
    localparam logic [3:0] ALU_OR      = 4'd8;
    localparam logic [3:0] ALU_XOR     = 4'd9;
    localparam logic [3:0] ALU_SLTU    = 4'd10;
    localparam logic [3:0] ALU_SLT     = 4'd11;

    logic        clk;
    logic        rst [2];
    logic        req_valid [2][2];
    logic        req_ready [2][2];
    logic [3:0]  req_op [2][2];
    logic [31:0] req_a [2][2];
    logic [31:0] req_b [2][2];
    logic        rsp_valid [2][2];
    logic        rsp_ready [2][2];
    logic [31:0] rsp_data [2][2];
    logic [3:0]  alu_op [2];
    logic [31:0] alu_a [2];
    logic [31:0] alu_b [2];
    logic [31:0] alu_out [2];

    int checks = 0;
    int fails = 0;

    int          ph [2];
    int          own [2];
    int          last [2];
    logic [3:0]  mop [2];
    logic [31:0] ma [2];
    logic [31:0] mb [2];
    logic [31:0] mres [2];
    bit          chk_en;
    int          gq0 [$];
    int          gq1 [$];

    function automatic logic [31:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_SHIFTL:  return a << b[4:0];
            ALU_SHIFTR:  return a >> b[4:0];
            ALU_SHIFTRA: return 32'($signed(a) >>> b[4:0]);
            ALU_ADD:     return a + b;
            ALU_SUB:     return a - b;
            ALU_AND:     return a & b;
            ALU_OR:      return a | b;
            ALU_XOR:     return a ^ b;
            ALU_SLTU:    return {31'd0, a < b};
            ALU_SLT:     return {31'd0, $signed(a) < $signed(b)};
            default:     return 32'd0;
        endcase
    endfunction

    always_comb alu_out[0] = alu_f(alu_op[0], alu_a[0], alu_b[0]);
    always_comb alu_out[1] = alu_f(alu_op[1], alu_a[1], alu_b[1]);

    alu_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk_i(clk), .rst_i(rst[0]),
        .req0_valid_i(req_valid[0][0]), .req0_ready_o(req_ready[0][0]),
        .req0_op_i(req_op[0][0]), .req0_a_i(req_a[0][0]), .req0_b_i(req_b[0][0]),
        .req1_valid_i(req_valid[0][1]), .req1_ready_o(req_ready[0][1]),
        .req1_op_i(req_op[0][1]), .req1_a_i(req_a[0][1]), .req1_b_i(req_b[0][1]),
        .rsp0_valid_o(rsp_valid[0][0]), .rsp0_ready_i(rsp_ready[0][0]),
        .rsp0_data_o(rsp_data[0][0]),
        .rsp1_valid_o(rsp_valid[0][1]), .rsp1_ready_i(rsp_ready[0][1]),
        .rsp1_data_o(rsp_data[0][1]),
        .alu_op_o(alu_op[0]), .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]),
        .alu_out_i(alu_out[0])
    );

    alu_arbiter #(.FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .rst_i(rst[1]),
        .req0_valid_i(req_valid[1][0]), .req0_ready_o(req_ready[1][0]),
        .req0_op_i(req_op[1][0]), .req0_a_i(req_a[1][0]), .req0_b_i(req_b[1][0]),
        .req1_valid_i(req_valid[1][1]), .req1_ready_o(req_ready[1][1]),
        .req1_op_i(req_op[1][1]), .req1_a_i(req_a[1][1]), .req1_b_i(req_b[1][1]),
        .rsp0_valid_o(rsp_valid[1][0]), .rsp0_ready_i(rsp_ready[1][0]),
        .rsp0_data_o(rsp_data[1][0]),
        .rsp1_valid_o(rsp_valid[1][1]), .rsp1_ready_i(rsp_ready[1][1]),
        .rsp1_data_o(rsp_data[1][1]),
        .alu_op_o(alu_op[1]), .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]),
        .alu_out_i(alu_out[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int d, int n, logic v, logic [3:0] op,
                           logic [31:0] a, logic [31:0] b);
        req_valid[d][n] = v;
        req_op[d][n] = op;
        req_a[d][n] = a;
        req_b[d][n] = b;
    endtask

    task automatic quiet(int d);
        rst[d] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            set_req(d, n, 1'b0, 4'd0, 32'd0, 32'd0);
            rsp_ready[d][n] = 1'b1;
        end
    endtask

    // Check both instances against the model at the falling edge, then advance.
    task automatic cyc();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int w;
            w = -1;
            if (ph[d] == 0) begin
                if (req_valid[d][0] && req_valid[d][1])
                    w = (d == 1) ? 0 : (last[d] == 0 ? 1 : 0);
                else if (req_valid[d][0])
                    w = 0;
                else if (req_valid[d][1])
                    w = 1;
            end
            if (chk_en) begin
                chk($sformatf("d%0d_req0_ready", d), 32'(req_ready[d][0]), 32'(w == 0));
                chk($sformatf("d%0d_req1_ready", d), 32'(req_ready[d][1]), 32'(w == 1));
                chk($sformatf("d%0d_rsp0_valid", d), 32'(rsp_valid[d][0]),
                    32'(ph[d] == 2 && own[d] == 0));
                chk($sformatf("d%0d_rsp1_valid", d), 32'(rsp_valid[d][1]),
                    32'(ph[d] == 2 && own[d] == 1));
                chk($sformatf("d%0d_rsp0_data", d), rsp_data[d][0], mres[d]);
                chk($sformatf("d%0d_rsp1_data", d), rsp_data[d][1], mres[d]);
                chk($sformatf("d%0d_alu_op", d), 32'(alu_op[d]), 32'(mop[d]));
                chk($sformatf("d%0d_alu_a", d), alu_a[d], ma[d]);
                chk($sformatf("d%0d_alu_b", d), alu_b[d], mb[d]);
            end
            for (int n = 0; n < 2; n++) begin
                if (req_valid[d][n] === 1'b1 && req_ready[d][n] === 1'b1 && !rst[d]) begin
                    if (d == 0) gq0.push_back(n);
                    else gq1.push_back(n);
                end
            end
            if (rst[d]) begin
                ph[d] = 0; own[d] = 0; last[d] = 1;
                mop[d] = 4'd0; ma[d] = 32'd0; mb[d] = 32'd0; mres[d] = 32'd0;
            end else if (ph[d] == 0) begin
                if (w >= 0) begin
                    ph[d] = 1; own[d] = w; last[d] = w;
                    mop[d] = req_op[d][w]; ma[d] = req_a[d][w]; mb[d] = req_b[d][w];
                end
            end else if (ph[d] == 1) begin
                mres[d] = alu_f(mop[d], ma[d], mb[d]);
                ph[d] = 2;
            end else if (rsp_ready[d][own[d]]) begin
                ph[d] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst(int d);
        rst[d] = 1'b1;
        cyc();
        rst[d] = 1'b0;
        if (d == 0) gq0.delete();
        else gq1.delete();
    endtask

    function automatic logic [3:0] grant_pat(int d);
        logic [3:0] p;
        p = 4'bxxxx;
        for (int i = 0; i < 4; i++) begin
            if (d == 0 && i < gq0.size()) p[i] = gq0[i][0];
            if (d == 1 && i < gq1.size()) p[i] = gq1[i][0];
        end
        return p;
    endfunction

    logic [3:0] ops [10];

    initial begin
        ops = '{ALU_SHIFTL, ALU_SHIFTR, ALU_SHIFTRA, ALU_ADD, ALU_SUB,
                ALU_AND, ALU_OR, ALU_XOR, ALU_SLTU, ALU_SLT};
        chk_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; own[d] = 0; last[d] = 1;
            mop[d] = 0; ma[d] = 0; mb[d] = 0; mres[d] = 0;
            quiet(d);
            rst[d] = 1'b1;
        end
        cyc();
        quiet(0);
        quiet(1);
        chk_en = 1'b1;
        gq0.delete();
        gq1.delete();
        cyc();

        // Single op on requester 0.
        set_req(0, 0, 1'b1, ALU_ADD, 32'd5, 32'd7);
        cyc();
        set_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
        cyc();
        chk("single_valid", 32'(rsp_valid[0][0]), 32'd1);
        chk("single_data", rsp_data[0][0], 32'h0000000C);
        chk("single_rsp1", 32'(rsp_valid[0][1]), 32'd0);
        cyc();
        cyc();

        // Round-robin contention.
        pulse_rst(0);
        set_req(0, 0, 1'b1, ALU_SUB, 32'd3, 32'd5);
        set_req(0, 1, 1'b1, ALU_XOR, 32'h0000F0F0, 32'h00000FF0);
        repeat (12) begin
            cyc();
            if (rsp_valid[0][0]) chk("rr_data0", rsp_data[0][0], 32'hFFFFFFFE);
            if (rsp_valid[0][1]) chk("rr_data1", rsp_data[0][1], 32'h0000FF00);
        end
        chk("rr_order", 32'(grant_pat(0)), 32'(4'b1010));
        quiet(0);
        repeat (3) cyc();

        // Fixed priority contention.
        pulse_rst(1);
        set_req(1, 0, 1'b1, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1, 1'b1, ALU_OR, 32'h10, 32'h01);
        repeat (9) cyc();
        set_req(1, 0, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (4) cyc();
        chk("fp_order", 32'(grant_pat(1)), 32'(4'b1000));
        quiet(1);
        repeat (3) cyc();

        // Backpressure on requester 1.
        pulse_rst(0);
        set_req(0, 1, 1'b1, ALU_SLT, 32'hFFFFFFFF, 32'd1);
        rsp_ready[0][1] = 1'b0;
        cyc();
        set_req(0, 1, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(0, 0, 1'b1, ALU_AND, 32'hFF, 32'h0F);
        cyc();
        repeat (5) begin
            chk("bp_valid", 32'(rsp_valid[0][1]), 32'd1);
            chk("bp_data", rsp_data[0][1], 32'h00000001);
            cyc();
        end
        chk("bp_no_hs", 32'(gq0.size()), 32'd1);
        rsp_ready[0][1] = 1'b1;
        cyc();
        chk("bp_released", 32'(rsp_valid[0][1]), 32'd0);
        cyc();
        chk("bp_next_hs", 32'(gq0.size()), 32'd2);
        quiet(0);
        repeat (3) cyc();

        // Reset while a response is pending.
        pulse_rst(0);
        set_req(0, 0, 1'b1, ALU_ADD, 32'd1, 32'd2);
        rsp_ready[0][0] = 1'b0;
        cyc();
        set_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
        cyc();
        chk("rst_pre_valid", 32'(rsp_valid[0][0]), 32'd1);
        pulse_rst(0);
        chk("rst_valid0", 32'(rsp_valid[0][0]), 32'd0);
        chk("rst_valid1", 32'(rsp_valid[0][1]), 32'd0);
        chk("rst_data", rsp_data[0][0], 32'd0);
        rsp_ready[0][0] = 1'b1;
        set_req(0, 0, 1'b1, ALU_OR, 32'h3, 32'h4);
        set_req(0, 1, 1'b1, ALU_OR, 32'h5, 32'h6);
        cyc();
        chk("rst_first_grant", 32'(grant_pat(0)), 32'(4'bxxx0));
        quiet(0);
        repeat (3) cyc();

        // Requester 1 pulses valid while busy.
        pulse_rst(0);
        set_req(0, 0, 1'b1, ALU_ADD, 32'd9, 32'd9);
        cyc();
        set_req(0, 0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(0, 1, 1'b1, ALU_SUB, 32'd9, 32'd1);
        cyc();
        set_req(0, 1, 1'b0, 4'd0, 32'd0, 32'd0);
        cyc();
        set_req(0, 0, 1'b1, ALU_XOR, 32'd1, 32'd2);
        set_req(0, 1, 1'b1, ALU_XOR, 32'd3, 32'd4);
        cyc();
        chk("wd_order", 32'(grant_pat(0)), 32'(4'bxx10));
        quiet(0);
        repeat (3) cyc();

        // Randomised traffic on both instances.
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                rst[d] = ($urandom_range(0, 59) == 0);
                for (int n = 0; n < 2; n++) begin
                    set_req(d, n, 1'($urandom_range(0, 1)),
                            ops[$urandom_range(0, 9)], $urandom(),
                            ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 40)));
                    rsp_ready[d][n] = ($urandom_range(0, 3) != 0);
                end
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = requester 0 always wins.
REQ-002 The block SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 The block SHALL have, for n in {0,1}, port req<n>_valid_i, input, 1, requester n has an operation pending.
REQ-005 The block SHALL have port req<n>_ready_o, output, 1, operation from requester n accepted this cycle.
REQ-006 The block SHALL have port req<n>_op_i, input, 4, ALU opcode using the ALU_* encodings in riscv_defs.v.
REQ-007 The block SHALL have ports req<n>_a_i and req<n>_b_i, input, 32, operands.
REQ-008 The block SHALL have port rsp<n>_valid_o, output, 1, result for requester n available.
REQ-009 The block SHALL have port rsp<n>_ready_i, input, 1, requester n consumes the result.
REQ-010 The block SHALL have port rsp<n>_data_o, output, 32, result value.
REQ-011 The block SHALL have ports alu_op_o (output, 4), alu_a_o and alu_b_o (output, 32 each), driving the shared combinational ALU.
REQ-012 The block SHALL have port alu_out_i, input, 32, shared ALU result.

Function
REQ-013 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-014 IDLE: the block SHALL assert req<g>_ready_o only for the winner g when any req valid is high; all ready signals SHALL be low in EXEC and RESP.
REQ-015 Handshake: when req<g>_valid_i and req<g>_ready_o are both high, the block SHALL latch op/a/b, record g, and go to EXEC.
REQ-016 Arbitration with FIXED_PRIO=0 SHALL grant the requester not granted last when both are valid; a lone valid requester SHALL always win.
REQ-017 Arbitration with FIXED_PRIO=1 SHALL grant requester 0 whenever req0_valid_i is high.
REQ-018 The last-grant pointer SHALL update only on a request handshake.
REQ-019 alu_op_o, alu_a_o and alu_b_o SHALL always equal the latched op/a/b registers, holding their values outside EXEC.
REQ-020 EXEC: the block SHALL capture alu_out_i into the result register and go to RESP after exactly one cycle.
REQ-021 RESP: rsp<g>_valid_o SHALL be 1 and rsp<g>_data_o SHALL equal the result register; the other rsp valid SHALL be 0.
REQ-022 RESP: rsp<g>_data_o SHALL stay stable until rsp<g>_ready_i is high; on that edge the block SHALL go to IDLE.
REQ-023 The result register SHALL pass through unmodified (32 bits, no extension or truncation).
REQ-024 Latency: a handshake at edge T SHALL make rsp valid in the cycle after edge T+1; peak throughput is one op per 3 cycles while rsp ready is held high.
REQ-025 rsp<n>_data_o SHALL drive the result register for both n; only valid distinguishes the owner.
REQ-026 A requester dropping valid before handshake SHALL have no effect; operands SHALL be sampled only at handshake.
REQ-027 The block SHALL ignore rsp<n>_ready_i while rsp<n>_valid_o is low.

Reset
REQ-028 On rst_i high at a clock edge, the block SHALL go to IDLE, clear all ready/valid outputs, zero the op/a/b and result registers, and set the last-grant pointer to 1 so requester 0 wins first.
REQ-029 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued; rst_i SHALL take priority over all other inputs.

Verification
REQ-030 Single op: req0 ALU_ADD a=5 b=7 at T -> rsp0_valid=1, data=0x0000000C after T+1; req1 untouched.
REQ-031 Contention, FIXED_PRIO=0: both valid continuously, rsp ready tied high -> grants alternate 0,1,0,1; req0 ALU_SUB 3-5 gives 0xFFFFFFFE, req1 ALU_XOR 0xF0F0 ^ 0x0FF0 gives 0x0000FF00.
REQ-032 Contention, FIXED_PRIO=1: both valid for 3 ops -> all three grants to requester 0; requester 1 is granted only after req0_valid drops.
REQ-033 Backpressure: rsp1_ready low for 5 cycles with ALU_LESS_THAN_SIGNED a=0xFFFFFFFF b=1 -> rsp1_data holds 0x00000001, no new handshake occurs, IDLE follows the ready edge.
REQ-034 Reset in RESP with rsp0_valid high -> next cycle all valids 0, state IDLE; the next simultaneous request grants requester 0.
REQ-035 Withdrawn request: req1_valid pulses while the block is in EXEC -> no req1_ready, no rsp1_valid, arbitration pointer unchanged.
